// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the complementary PWM dead-time generator.
package pwm_deadtime_pkg;

  localparam int NUM_CH_DEF   = 3;
  localparam int DT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LS_ON   = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HS_ON   = 3'd3,
    ST_DT_FALL = 3'd4
  } ch_state_e;

endpackage

// File: rtl/pwm_deadtime_ch.sv
// One complementary gate channel: FSM, dead-time down-counter, registered outputs, sticky error.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_OFF     | channel disabled, both switches off
//  ST_LS_ON   | low-side switch on
//  ST_DT_RISE | dead time before turning high side on (pwm went high)
//  ST_HS_ON   | high-side switch on
//  ST_DT_FALL | dead time before turning low side on (pwm went low / start)
module pwm_deadtime_ch
  import pwm_deadtime_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                err_clear,
  output logic                hs_out,
  output logic                ls_out,
  output logic                dt_active,
  output logic                pulse_err
);

  ch_state_e           state, state_nxt;
  logic [DT_WIDTH-1:0] cnt, cnt_nxt;
  logic                err_set;
  logic                dt_zero, cnt_last;

  assign dt_zero  = (dead_time == '0);
  assign cnt_last = (cnt == DT_WIDTH'(1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    if (!enable) begin
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (dt_zero) state_nxt = ST_LS_ON;
          else begin
            state_nxt = ST_DT_FALL;
            cnt_nxt   = dead_time;
          end
        end
        ST_LS_ON: begin
          if (pwm_in) begin
            if (dt_zero) state_nxt = ST_HS_ON;
            else begin
              state_nxt = ST_DT_RISE;
              cnt_nxt   = dead_time;
            end
          end
        end
        ST_DT_RISE: begin
          cnt_nxt = cnt - 1'b1;
          if (!pwm_in) begin
            state_nxt = ST_LS_ON;
            err_set   = 1'b1;
          end else if (cnt_last) begin
            state_nxt = ST_HS_ON;
          end
        end
        ST_HS_ON: begin
          if (!pwm_in) begin
            if (dt_zero) state_nxt = ST_LS_ON;
            else begin
              state_nxt = ST_DT_FALL;
              cnt_nxt   = dead_time;
            end
          end
        end
        ST_DT_FALL: begin
          cnt_nxt = cnt - 1'b1;
          if (pwm_in) begin
            state_nxt = ST_HS_ON;
            err_set   = 1'b1;
          end else if (cnt_last) begin
            state_nxt = ST_LS_ON;
          end
        end
        default: begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_OFF;
      cnt       <= '0;
      hs_out    <= 1'b0;
      ls_out    <= 1'b0;
      dt_active <= 1'b0;
      pulse_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hs_out    <= (state_nxt == ST_HS_ON);
      ls_out    <= (state_nxt == ST_LS_ON);
      dt_active <= (state_nxt == ST_DT_RISE) || (state_nxt == ST_DT_FALL);
      pulse_err <= err_set | (pulse_err & ~err_clear);
    end
  end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low-side gate generator with dead time for NUM_CH independent PWM channels.
module pwm_deadtime_gen
  import pwm_deadtime_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic [NUM_CH-1:0]   pwm_in,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                err_clear,
  output logic [NUM_CH-1:0]   hs_out,
  output logic [NUM_CH-1:0]   ls_out,
  output logic [NUM_CH-1:0]   dt_active,
  output logic [NUM_CH-1:0]   pulse_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_en;
    assign ch_en = enable & ch_enable[i];

    pwm_deadtime_ch #(
      .DT_WIDTH (DT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enable    (ch_en),
      .pwm_in    (pwm_in[i]),
      .dead_time (dead_time),
      .err_clear (err_clear),
      .hs_out    (hs_out[i]),
      .ls_out    (ls_out[i]),
      .dt_active (dt_active[i]),
      .pulse_err (pulse_err[i])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen; pwm_in is driven directly with hand-timed pulses.
module tb_pwm_deadtime_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] ch_enable;
  logic [2:0] pwm_in;
  logic [7:0] dead_time;
  logic       err_clear;
  logic [2:0] hs_out, ls_out, dt_active, pulse_err;

  int n_cmp = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  pwm_deadtime_gen #(.NUM_CH(3), .DT_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ch_enable (ch_enable),
    .pwm_in    (pwm_in),
    .dead_time (dead_time),
    .err_clear (err_clear),
    .hs_out    (hs_out),
    .ls_out    (ls_out),
    .dt_active (dt_active),
    .pulse_err (pulse_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_cnt, ls_cnt, dt_cnt, ovl_cnt, bad;
    int hs_seen;
    logic p;

    reset = 1'b1; enable = 1'b0; ch_enable = 3'b000; pwm_in = 3'b000;
    dead_time = 8'd4; err_clear = 1'b0;
    tick(); tick();
    chk("rst_hs", hs_out, 0);
    chk("rst_ls", ls_out, 0);
    chk("rst_dt", dt_active, 0);
    chk("rst_err", pulse_err, 0);

    reset = 1'b0;
    tick(); tick(); tick();
    chk("dis_hs", hs_out, 0);
    chk("dis_ls", ls_out, 0);
    chk("dis_dt", dt_active, 0);

    // 1: enable -> 4 cycles in DT_FALL, then low side on
    enable = 1'b1; ch_enable = 3'b111;
    tick();
    chk("en_dt_first", dt_active, 3'b111);
    chk("en_ls_first", ls_out, 0);
    tick(); tick(); tick();
    chk("en_dt_last", dt_active, 3'b111);
    chk("en_ls_last", ls_out, 0);
    tick();
    chk("en_ls_on", ls_out, 3'b111);
    chk("en_hs_off", hs_out, 0);
    chk("en_dt_off", dt_active, 0);

    // 2: ch0 25-cycle pulse in a 100-cycle period, dead_time=4
    hs_cnt = 0; ls_cnt = 0; dt_cnt = 0; ovl_cnt = 0;
    for (int j = 0; j < 100; j++) begin
      pwm_in[0] = (j < 25);
      tick();
      hs_cnt  += int'(hs_out[0]);
      ls_cnt  += int'(ls_out[0]);
      dt_cnt  += int'(dt_active[0]);
      ovl_cnt += int'(|(hs_out & ls_out));
    end
    chk("d25_hs_cycles", hs_cnt, 21);
    chk("d25_ls_cycles", ls_cnt, 71);
    chk("d25_dt_cycles", dt_cnt, 8);
    chk("d25_overlap", ovl_cnt, 0);

    // 3: ch1 3-cycle pulse with dead_time=5 is swallowed
    dead_time = 8'd5;
    hs_seen = 0;
    for (int j = 0; j < 10; j++) begin
      pwm_in[1] = (j < 3);
      tick();
      hs_seen += int'(hs_out[1]);
    end
    chk("swl_hs_never", hs_seen, 0);
    chk("swl_ls_back", ls_out[1], 1);
    chk("swl_err_set", pulse_err, 3'b010);
    tick(); tick(); tick();
    chk("swl_err_sticky", pulse_err, 3'b010);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("swl_err_cleared", pulse_err, 0);

    // set and clear in the same cycle: set wins
    pwm_in[1] = 1'b1; tick();
    tick();
    pwm_in[1] = 1'b0; err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("swl_set_wins", pulse_err, 3'b010);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("swl_clear2", pulse_err, 0);

    // 4: dead_time=0, ch2 50% duty follows pwm_in with one cycle latency
    dead_time = 8'd0;
    bad = 0; dt_cnt = 0;
    for (int j = 0; j < 100; j++) begin
      p = (j < 50);
      pwm_in[2] = p;
      tick();
      if (hs_out[2] !== p)  bad++;
      if (ls_out[2] !== ~p) bad++;
      dt_cnt += int'(dt_active[2]);
    end
    chk("dt0_follow", bad, 0);
    chk("dt0_no_dt", dt_cnt, 0);

    // 6: dead_time 4->10 during a gap
    dead_time = 8'd4;
    pwm_in[0] = 1'b1;
    tick();
    dead_time = 8'd10;
    dt_cnt = int'(dt_active[0]);
    for (int j = 0; j < 19; j++) begin
      tick();
      dt_cnt += int'(dt_active[0]);
    end
    chk("dtchg_gap_cur", dt_cnt, 4);
    chk("dtchg_hs_on", hs_out[0], 1);
    pwm_in[0] = 1'b0;
    dt_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      dt_cnt += int'(dt_active[0]);
    end
    chk("dtchg_gap_next", dt_cnt, 10);
    chk("dtchg_ls_on", ls_out[0], 1);

    // 5: drop ch_enable[0] while high side on
    dead_time = 8'd4;
    pwm_in[0] = 1'b1;
    for (int j = 0; j < 10; j++) tick();
    chk("chdis_pre_hs", hs_out[0], 1);
    ch_enable[0] = 1'b0;
    tick();
    chk("chdis_hs", hs_out[0], 0);
    chk("chdis_ls", ls_out[0], 0);
    chk("chdis_other", ls_out, 3'b110);

    // async reset during DT_RISE
    pwm_in[0] = 1'b0; ch_enable = 3'b111;
    for (int j = 0; j < 6; j++) tick();
    chk("reen_ls", ls_out[0], 1);
    pwm_in[0] = 1'b1;
    tick(); tick();
    chk("rise_dt", dt_active[0], 1);
    #3 reset = 1'b1;
    #2;
    chk("arst_hs", hs_out, 0);
    chk("arst_ls", ls_out, 0);
    chk("arst_dt", dt_active, 0);
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
